mem_stage_lsu: RTL and testbench



---
 rtl/mem_stage_lsu.sv | 208 ++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Pipeline memory stage: req/gnt/rvalid data-memory access, load lane extraction, memory exceptions, flush, ID forwarding.
// Optional feature: define MEM_MISALIGN_EXC_EN to trap misaligned accesses instead of forcing natural alignment.
module mem_stage_lsu #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RAW         = 5,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_to_mem_valid,
    output logic              mem_allow_in,
    input  logic [1:0]        ex_kind,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsigned,
    input  logic [XLEN-1:0]   ex_addr,
    input  logic [XLEN-1:0]   ex_wdata,
    input  logic              ex_rf_we,
    input  logic [RAW-1:0]    ex_wb_reg,
    input  logic [XLEN-1:0]   ex_wb_data,
    input  logic              flush,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN/8-1:0] dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_err,
    input  logic              wb_allow_in,
    output logic              mem_to_wb_valid,
    output logic              wb_rf_we,
    output logic [RAW-1:0]    wb_reg,
    output logic [XLEN-1:0]   wb_data,
    output logic              mem_exc,
    output logic [1:0]        mem_exc_code,
    output logic              fwd_valid,
    output logic              fwd_rf_we,
    output logic              fwd_pending,
    output logic [RAW-1:0]    fwd_reg,
    output logic [XLEN-1:0]   fwd_data
);

    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);
    localparam int unsigned CW   = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt;
    logic              is_load_r, is_store_r, unsigned_r, rf_we_r, exc_r;
    logic [1:0]        size_r, code_r;
    logic [OFFW-1:0]   off_r;
    logic [XLEN-1:0]   addr_r, wdata_r, data_r;
    logic [NB-1:0]     be_r;
    logic [RAW-1:0]    reg_r;

    logic              ex_is_load, ex_is_store, ex_is_mem, ex_trap;
    logic [1:0]        ex_size_eff;
    logic [OFFW-1:0]   ex_off, lo_mask, ex_off_al;
    logic [NB-1:0]     ex_be;
    logic              valid, ready_go, capture, tmo_hit, resp_end;
    logic [XLEN-1:0]   rd_sh, ld_mask, ld_val;
    logic              ld_sign;
    state_t            cap_state;

    // Access decode for the instruction presented by EX
    assign ex_is_load  = (ex_kind == 2'b01);
    assign ex_is_store = (ex_kind == 2'b10);
    assign ex_is_mem   = ex_is_load || ex_is_store;
    assign ex_size_eff = (XLEN == 32 && ex_size == 2'b11) ? 2'b10 : ex_size;
    assign ex_off      = ex_addr[OFFW-1:0];
    assign lo_mask     = OFFW'((32'd1 << ex_size_eff) - 32'd1);
    assign ex_off_al   = ex_off & ~lo_mask;
    assign ex_be       = NB'(((32'd1 << (32'd1 << ex_size_eff)) - 32'd1) << ex_off_al);

`ifdef MEM_MISALIGN_EXC_EN
    assign ex_trap = ex_is_mem && (|(ex_off & lo_mask));
`else
    assign ex_trap = 1'b0;
`endif

    assign cap_state = (ex_is_mem && !ex_trap) ? S_REQ : S_DONE;

    assign valid        = (state == S_REQ) || (state == S_WAIT) || (state == S_DONE);
    assign ready_go     = (state == S_DONE);
    assign mem_allow_in = (state == S_IDLE) || (ready_go && wb_allow_in && !flush);
    assign capture      = mem_allow_in && ex_to_mem_valid;
    assign tmo_hit      = (cnt == CW'(TIMEOUT_CYC - 1));
    assign resp_end     = dmem_rvalid || tmo_hit;

    // Load lane extraction and extension from the raw read word
    always_comb begin
        rd_sh   = dmem_rdata >> {off_r, 3'b000};
        ld_mask = '1;
        ld_sign = rd_sh[XLEN-1];
        case (size_r)
            2'b00: begin ld_mask = XLEN'(32'h0000_00FF); ld_sign = rd_sh[7];  end
            2'b01: begin ld_mask = XLEN'(32'h0000_FFFF); ld_sign = rd_sh[15]; end
            2'b10: begin ld_mask = XLEN'(32'hFFFF_FFFF); ld_sign = rd_sh[31]; end
            default: ;
        endcase
        ld_val = (rd_sh & ld_mask) | ((!unsigned_r && ld_sign) ? ~ld_mask : '0);
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (capture) state_n = cap_state;
            S_REQ: begin
                if (flush)         state_n = S_IDLE;
                else if (dmem_gnt) state_n = S_WAIT;
            end
            S_WAIT: begin
                // A flush coinciding with the response has nothing left to drain
                if (flush)         state_n = resp_end ? S_IDLE : S_DRAIN;
                else if (resp_end) state_n = S_DONE;
            end
            S_DRAIN: if (resp_end) state_n = S_IDLE;
            S_DONE: begin
                if (flush)            state_n = S_IDLE;
                else if (wb_allow_in) state_n = capture ? cap_state : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            is_load_r  <= 1'b0;
            is_store_r <= 1'b0;
            unsigned_r <= 1'b0;
            rf_we_r    <= 1'b0;
            exc_r      <= 1'b0;
            size_r     <= '0;
            code_r     <= '0;
            off_r      <= '0;
            addr_r     <= '0;
            wdata_r    <= '0;
            data_r     <= '0;
            be_r       <= '0;
            reg_r      <= '0;
        end else begin
            state <= state_n;
            if ((state == S_WAIT || state == S_DRAIN) && (state_n == S_WAIT || state_n == S_DRAIN))
                cnt <= cnt + CW'(1);
            else
                cnt <= '0;

            if (capture) begin
                is_load_r  <= ex_is_load;
                is_store_r <= ex_is_store;
                unsigned_r <= ex_unsigned;
                rf_we_r    <= ex_rf_we;
                size_r     <= ex_size_eff;
                off_r      <= ex_off_al;
                addr_r     <= {ex_addr[XLEN-1:OFFW], OFFW'(0)};
                be_r       <= ex_be;
                wdata_r    <= ex_wdata << {ex_off_al, 3'b000};
                reg_r      <= ex_wb_reg;
                data_r     <= ex_wb_data;
                exc_r      <= ex_trap;
                code_r     <= ex_trap ? (ex_is_load ? 2'b01 : 2'b10) : 2'b00;
            end else if (state == S_WAIT && !flush) begin
                if (dmem_rvalid) begin
                    if (dmem_err) begin
                        exc_r  <= 1'b1;
                        code_r <= 2'b11;
                    end else if (is_load_r) begin
                        data_r <= ld_val;
                    end
                end else if (tmo_hit) begin
                    exc_r  <= 1'b1;
                    code_r <= 2'b11;
                end
            end
        end
    end

    assign dmem_req   = (state == S_REQ) && !flush;
    assign dmem_we    = dmem_req && is_store_r;
    assign dmem_addr  = addr_r;
    assign dmem_be    = be_r;
    assign dmem_wdata = wdata_r;

    assign mem_to_wb_valid = ready_go && !flush;
    assign wb_rf_we        = valid && rf_we_r && !is_store_r && !exc_r;
    assign wb_reg          = reg_r;
    assign wb_data         = data_r;
    assign mem_exc         = ready_go && exc_r && !flush;
    assign mem_exc_code    = mem_exc ? code_r : 2'b00;

    assign fwd_valid   = valid;
    assign fwd_rf_we   = wb_rf_we;
    assign fwd_pending = valid && is_load_r && !ready_go;
    assign fwd_reg     = reg_r;
    assign fwd_data    = data_r;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu (XLEN=32, TIMEOUT_CYC=4).
module tb_mem_stage_lsu;

    logic        clk, rst;
    logic        ex_to_mem_valid, mem_allow_in;
    logic [1:0]  ex_kind, ex_size;
    logic        ex_unsigned;
    logic [31:0] ex_addr, ex_wdata, ex_wb_data;
    logic        ex_rf_we;
    logic [4:0]  ex_wb_reg;
    logic        flush;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid, dmem_err;
    logic        wb_allow_in, mem_to_wb_valid, wb_rf_we;
    logic [4:0]  wb_reg, fwd_reg;
    logic [31:0] wb_data, fwd_data;
    logic        mem_exc;
    logic [1:0]  mem_exc_code;
    logic        fwd_valid, fwd_rf_we, fwd_pending;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage_lsu #(.XLEN(32), .RAW(5), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .ex_to_mem_valid(ex_to_mem_valid), .mem_allow_in(mem_allow_in),
        .ex_kind(ex_kind), .ex_size(ex_size), .ex_unsigned(ex_unsigned),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_rf_we(ex_rf_we), .ex_wb_reg(ex_wb_reg), .ex_wb_data(ex_wb_data),
        .flush(flush),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .dmem_err(dmem_err),
        .wb_allow_in(wb_allow_in), .mem_to_wb_valid(mem_to_wb_valid),
        .wb_rf_we(wb_rf_we), .wb_reg(wb_reg), .wb_data(wb_data),
        .mem_exc(mem_exc), .mem_exc_code(mem_exc_code),
        .fwd_valid(fwd_valid), .fwd_rf_we(fwd_rf_we), .fwd_pending(fwd_pending),
        .fwd_reg(fwd_reg), .fwd_data(fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] kind, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic we,
                          input logic [4:0] rg, input logic [31:0] data);
        ex_to_mem_valid = 1'b1;
        ex_kind = kind; ex_size = size; ex_unsigned = uns;
        ex_addr = addr; ex_wdata = wd; ex_rf_we = we;
        ex_wb_reg = rg; ex_wb_data = data;
    endtask

    task automatic idle_ex();
        ex_to_mem_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ex_to_mem_valid = 0; ex_kind = 0; ex_size = 0; ex_unsigned = 0;
        ex_addr = 0; ex_wdata = 0; ex_rf_we = 0; ex_wb_reg = 0; ex_wb_data = 0;
        flush = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0; dmem_err = 0;
        wb_allow_in = 1'b1;
        #2;
        chk("rst_allow", mem_allow_in, 1);
        chk("rst_m2wb", mem_to_wb_valid, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_exc", mem_exc, 0);
        chk("rst_fwd_valid", fwd_valid, 0);
        chk("rst_fwd_pend", fwd_pending, 0);
        chk("rst_wb_data", wb_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Non-memory ops back to back
        set_op(2'b00, 2'b10, 0, 0, 0, 1, 5'd5, 32'h1234);
        #1 chk("t1_allow", mem_allow_in, 1);
        step();
        set_op(2'b00, 2'b10, 0, 0, 0, 1, 5'd6, 32'h5678);
        #1;
        chk("t1_m2wb", mem_to_wb_valid, 1);
        chk("t1_data", wb_data, 32'h1234);
        chk("t1_reg", wb_reg, 5);
        chk("t1_we", wb_rf_we, 1);
        chk("t1_allow2", mem_allow_in, 1);
        chk("t1_pend", fwd_pending, 0);
        step();
        idle_ex();
        #1;
        chk("t1_m2wb2", mem_to_wb_valid, 1);
        chk("t1_data2", wb_data, 32'h5678);
        chk("t1_reg2", wb_reg, 6);
        step();
        #1;
        chk("t1_idle", mem_to_wb_valid, 0);
        chk("t1_fwd_valid", fwd_valid, 0);

        // lb at 0x103, immediate gnt, rvalid next cycle
        set_op(2'b01, 2'b00, 0, 32'h103, 0, 1, 5'd7, 32'hDEAD);
        #1;
        step();
        idle_ex(); dmem_gnt = 1;
        #1;
        chk("lb_req", dmem_req, 1);
        chk("lb_be", dmem_be, 4'b1000);
        chk("lb_addr", dmem_addr, 32'h100);
        chk("lb_we", dmem_we, 0);
        chk("lb_pend", fwd_pending, 1);
        chk("lb_allow", mem_allow_in, 0);
        chk("lb_m2wb_req", mem_to_wb_valid, 0);
        step();
        dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h80FF_FFFF;
        #1;
        chk("lb_req_wait", dmem_req, 0);
        chk("lb_m2wb_wait", mem_to_wb_valid, 0);
        step();
        dmem_rvalid = 0;
        #1;
        chk("lb_m2wb", mem_to_wb_valid, 1);
        chk("lb_data", wb_data, 32'hFFFF_FF80);
        chk("lb_we_wb", wb_rf_we, 1);
        chk("lb_pend_done", fwd_pending, 0);
        chk("lb_exc", mem_exc, 0);
        chk("lb_reg", wb_reg, 7);
        step();

        // lbu with a one-cycle WB stall
        set_op(2'b01, 2'b00, 1, 32'h103, 0, 1, 5'd8, 0);
        #1;
        step();
        idle_ex(); dmem_gnt = 1;
        step();
        dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h80FF_FFFF; wb_allow_in = 0;
        step();
        dmem_rvalid = 0;
        #1;
        chk("lbu_m2wb", mem_to_wb_valid, 1);
        chk("lbu_data", wb_data, 32'h80);
        chk("lbu_allow_stall", mem_allow_in, 0);
        step();
        chk("lbu_data_hold", wb_data, 32'h80);
        chk("lbu_m2wb_hold", mem_to_wb_valid, 1);
        wb_allow_in = 1;
        step();
        chk("lbu_gone", mem_to_wb_valid, 0);

        // sh 0xBEEF at 0x102, gnt delayed two cycles
        set_op(2'b10, 2'b01, 0, 32'h102, 32'hBEEF, 1, 5'd9, 0);
        #1;
        step();
        idle_ex();
        #1;
        chk("sh_req1", dmem_req, 1);
        chk("sh_be", dmem_be, 4'b1100);
        chk("sh_wdata", dmem_wdata, 32'hBEEF_0000);
        chk("sh_we", dmem_we, 1);
        step();
        chk("sh_req2", dmem_req, 1);
        step();
        dmem_gnt = 1;
        #1;
        chk("sh_req3", dmem_req, 1);
        chk("sh_be3", dmem_be, 4'b1100);
        step();
        dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 0;
        #1;
        chk("sh_req_wait", dmem_req, 0);
        step();
        dmem_rvalid = 0;
        #1;
        chk("sh_m2wb", mem_to_wb_valid, 1);
        chk("sh_rf_we", wb_rf_we, 0);
        chk("sh_fwd_we", fwd_rf_we, 0);
        chk("sh_exc", mem_exc, 0);
        step();

        // lw with no response: timeout after four WAIT cycles
        set_op(2'b01, 2'b10, 0, 32'h100, 0, 1, 5'd10, 0);
        #1;
        step();
        idle_ex(); dmem_gnt = 1;
        step();
        dmem_gnt = 0;
        #1 chk("to_wait1", mem_to_wb_valid, 0);
        step();
        step();
        step();
        chk("to_wait4", mem_to_wb_valid, 0);
        chk("to_pend", fwd_pending, 1);
        step();
        chk("to_m2wb", mem_to_wb_valid, 1);
        chk("to_exc", mem_exc, 1);
        chk("to_code", mem_exc_code, 2'b11);
        chk("to_rf_we", wb_rf_we, 0);
        step();
        dmem_rvalid = 1; dmem_err = 1; dmem_rdata = 32'hFFFF;
        set_op(2'b00, 2'b10, 0, 0, 0, 1, 5'd11, 32'hAAAA);
        #1;
        chk("late_allow", mem_allow_in, 1);
        chk("late_m2wb", mem_to_wb_valid, 0);
        chk("late_exc", mem_exc, 0);
        step();
        dmem_rvalid = 0; dmem_err = 0;
        idle_ex();
        #1;
        chk("late_next_m2wb", mem_to_wb_valid, 1);
        chk("late_next_data", wb_data, 32'hAAAA);
        chk("late_next_exc", mem_exc, 0);
        step();

        // flush in WAIT, response two cycles later
        set_op(2'b01, 2'b10, 0, 32'h200, 0, 1, 5'd12, 0);
        #1;
        step();
        idle_ex(); dmem_gnt = 1;
        step();
        dmem_gnt = 0; flush = 1;
        #1;
        chk("fl_m2wb", mem_to_wb_valid, 0);
        chk("fl_allow", mem_allow_in, 0);
        step();
        flush = 0;
        set_op(2'b00, 2'b10, 0, 0, 0, 1, 5'd13, 32'h7777);
        #1;
        chk("drain_allow", mem_allow_in, 0);
        chk("drain_m2wb", mem_to_wb_valid, 0);
        chk("drain_fwd_valid", fwd_valid, 0);
        chk("drain_exc", mem_exc, 0);
        step();
        dmem_rvalid = 1; dmem_rdata = 32'h1234_5678;
        #1;
        chk("drain_allow2", mem_allow_in, 0);
        chk("drain_m2wb2", mem_to_wb_valid, 0);
        step();
        dmem_rvalid = 0;
        #1;
        chk("fl_idle_allow", mem_allow_in, 1);
        chk("fl_idle_m2wb", mem_to_wb_valid, 0);
        step();
        idle_ex();
        #1;
        chk("fl_after_m2wb", mem_to_wb_valid, 1);
        chk("fl_after_data", wb_data, 32'h7777);
        chk("fl_after_reg", wb_reg, 13);

        // flush in DONE suppresses the handoff
        set_op(2'b00, 2'b10, 0, 0, 0, 1, 5'd14, 32'h4444);
        step();
        idle_ex(); flush = 1;
        #1;
        chk("fd_m2wb", mem_to_wb_valid, 0);
        chk("fd_exc", mem_exc, 0);
        step();
        flush = 0;
        #1;
        chk("fd_after_m2wb", mem_to_wb_valid, 0);
        chk("fd_after_valid", fwd_valid, 0);

        // lw at misaligned 0x102
        set_op(2'b01, 2'b10, 0, 32'h102, 0, 1, 5'd15, 0);
        #1;
        step();
`ifdef MEM_MISALIGN_EXC_EN
        idle_ex();
        #1;
        chk("mis_req", dmem_req, 0);
        chk("mis_m2wb", mem_to_wb_valid, 1);
        chk("mis_exc", mem_exc, 1);
        chk("mis_code", mem_exc_code, 2'b01);
        chk("mis_rf_we", wb_rf_we, 0);
        step();
`else
        idle_ex(); dmem_gnt = 1;
        #1;
        chk("mis_req", dmem_req, 1);
        chk("mis_addr", dmem_addr, 32'h100);
        chk("mis_be", dmem_be, 4'b1111);
        step();
        dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h1122_3344;
        step();
        dmem_rvalid = 0;
        #1;
        chk("mis_m2wb", mem_to_wb_valid, 1);
        chk("mis_data", wb_data, 32'h1122_3344);
        chk("mis_exc", mem_exc, 0);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
